// File: rtl/usb_rx_decoder_pkg.sv
// Shared USB receive definitions: PID codes, PID classes and decoder state.
// Imported by the packet decoder and intended for transmit/endpoint logic too.
package usb_rx_decoder_pkg;

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidSof   = 4'b0101;
    localparam logic [3:0] PidSetup = 4'b1101;
    localparam logic [3:0] PidPing  = 4'b0100;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidData2 = 4'b0111;
    localparam logic [3:0] PidMdata = 4'b1111;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [3:0] PidStall = 4'b1110;
    localparam logic [3:0] PidNyet  = 4'b0110;

    // Class is carried in the two low PID bits
    localparam logic [1:0] PidClsSpecial = 2'b00;
    localparam logic [1:0] PidClsToken   = 2'b01;
    localparam logic [1:0] PidClsHshake  = 2'b10;
    localparam logic [1:0] PidClsData    = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StToken,
        StData,
        StHshake,
        StDiscard
    } rx_state_e;

    function automatic rx_state_e pid_to_state(input logic [3:0] pid);
        rx_state_e st;
        st = StDiscard;
        case (pid[1:0])
            PidClsToken:  st = StToken;
            PidClsData:   st = StData;
            PidClsHshake: st = StHshake;
            default:      st = (pid == PidPing) ? StToken : StDiscard;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/usb_rx_crc_strip.sv
// Two-byte delay line: a byte leaves only when a newer one arrives, so the
// trailing CRC16 pair is never emitted.
module usb_rx_crc_strip (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       flush,
    input  logic [7:0] din,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic [1:0] occupancy
);

    logic [7:0] old_q, old_d, new_q, new_d;
    logic [1:0] occ_q, occ_d, occ_base;
    logic       emit;

    always_comb begin
        old_d    = old_q;
        new_d    = new_q;
        emit     = 1'b0;
        occ_base = flush ? 2'd0 : occ_q;
        occ_d    = occ_base;
        if (push) begin
            case (occ_base)
                2'd0: begin
                    old_d = din;
                    occ_d = 2'd1;
                end
                2'd1: begin
                    new_d = din;
                    occ_d = 2'd2;
                end
                default: begin
                    emit  = 1'b1;
                    old_d = new_q;
                    new_d = din;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            old_q     <= 8'd0;
            new_q     <= 8'd0;
            occ_q     <= 2'd0;
            out_valid <= 1'b0;
            out_byte  <= 8'd0;
        end else begin
            old_q     <= old_d;
            new_q     <= new_d;
            occ_q     <= occ_d;
            out_valid <= emit;
            if (emit) begin
                out_byte <= old_q;
            end
        end
    end

    assign occupancy = occ_q;

endmodule

// File: rtl/usb_rx_decoder.sv
// Packet-level USB receive decoder: classifies packets from usb_recv, extracts
// token/SOF fields, streams data payload without CRC16 and flags bad packets.
module usb_rx_decoder
    import usb_rx_decoder_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        xpacket,
    input  logic [3:0]  xpid,
    input  logic [7:0]  xdata,
    input  logic        xdatastrobe,
    input  logic        xcrc5_ok,
    input  logic        xcrc16_ok,
    output logic        tok_valid,
    output logic [3:0]  tok_pid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic        sof_valid,
    output logic [10:0] sof_frame,
    output logic        hs_valid,
    output logic [3:0]  hs_pid,
    output logic        data_start,
    output logic [3:0]  data_pid,
    output logic [7:0]  data_byte,
    output logic        data_strobe,
    output logic        data_end,
    output logic        data_ok,
    output logic        rx_error
);

    localparam int unsigned MaxBytes = MAX_PAYLOAD + 2;

    rx_state_e   state_q, state_d;
    logic        xpacket_q, pkt_rise, pkt_fall, in_pkt, line_push, have_crc;
    logic [1:0]  line_occ;
    logic [3:0]  pid_q, pid_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  b0_q, b0_d, b1_q, b1_d;
    logic        crc5_q, crc5_d, crc16_q, crc16_d;

    logic        tok_valid_d, sof_valid_d, hs_valid_d, data_start_d;
    logic        data_end_d, data_ok_d, rx_error_d;
    logic [3:0]  tok_pid_d, tok_endp_d, hs_pid_d, data_pid_d;
    logic [6:0]  tok_addr_d;
    logic [10:0] sof_frame_d;

    assign pkt_rise  = xpacket & ~xpacket_q;
    assign pkt_fall  = ~xpacket & xpacket_q;
    assign in_pkt    = (state_q != StIdle);
    assign line_push = (state_q == StData) && xdatastrobe;
    // Both CRC bytes are in the line, counting a push in the final cycle
    assign have_crc  = (line_occ == 2'd2) || ((line_occ == 2'd1) && line_push);

    always_comb begin
        state_d      = state_q;
        pid_d        = pid_q;
        cnt_d        = cnt_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        crc5_d       = crc5_q;
        crc16_d      = crc16_q;
        tok_valid_d  = 1'b0;
        sof_valid_d  = 1'b0;
        hs_valid_d   = 1'b0;
        data_start_d = 1'b0;
        data_end_d   = 1'b0;
        data_ok_d    = 1'b0;
        rx_error_d   = 1'b0;
        tok_pid_d    = tok_pid;
        tok_addr_d   = tok_addr;
        tok_endp_d   = tok_endp;
        sof_frame_d  = sof_frame;
        hs_pid_d     = hs_pid;
        data_pid_d   = data_pid;

        // Bytes are accounted before the end-of-packet decision below
        if (in_pkt && xdatastrobe) begin
            if (cnt_q != 11'h7ff) begin
                cnt_d = cnt_q + 11'd1;
            end
            if (cnt_q == 11'd0) begin
                b0_d = xdata;
            end
            if (cnt_q == 11'd1) begin
                b1_d   = xdata;
                crc5_d = xcrc5_ok;
            end
            crc16_d = xcrc16_ok;
        end

        if (in_pkt && pkt_fall) begin
            state_d = StIdle;
            case (state_q)
                StToken: begin
                    if ((cnt_d == 11'd2) && crc5_d) begin
                        if (pid_q == PidSof) begin
                            sof_valid_d = 1'b1;
                            sof_frame_d = {b1_d[2:0], b0_d};
                        end else begin
                            tok_valid_d = 1'b1;
                            tok_pid_d   = pid_q;
                            tok_addr_d  = b0_d[6:0];
                            tok_endp_d  = {b1_d[2:0], b0_d[7]};
                        end
                    end else begin
                        rx_error_d = 1'b1;
                    end
                end
                StHshake: begin
                    if (cnt_d == 11'd0) begin
                        hs_valid_d = 1'b1;
                        hs_pid_d   = pid_q;
                    end else begin
                        rx_error_d = 1'b1;
                    end
                end
                StData: begin
                    data_end_d = 1'b1;
                    data_ok_d  = have_crc && crc16_d && (32'(cnt_d) <= MaxBytes);
                end
                default: rx_error_d = 1'b1;
            endcase
        end else if (!in_pkt && pkt_rise) begin
            state_d = pid_to_state(xpid);
            pid_d   = xpid;
            cnt_d   = 11'd0;
            crc5_d  = 1'b0;
            crc16_d = 1'b0;
            if (state_d == StData) begin
                data_start_d = 1'b1;
                data_pid_d   = xpid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            xpacket_q  <= 1'b0;
            pid_q      <= 4'd0;
            cnt_q      <= 11'd0;
            b0_q       <= 8'd0;
            b1_q       <= 8'd0;
            crc5_q     <= 1'b0;
            crc16_q    <= 1'b0;
            tok_valid  <= 1'b0;
            sof_valid  <= 1'b0;
            hs_valid   <= 1'b0;
            data_start <= 1'b0;
            data_end   <= 1'b0;
            data_ok    <= 1'b0;
            rx_error   <= 1'b0;
            tok_pid    <= 4'd0;
            tok_addr   <= 7'd0;
            tok_endp   <= 4'd0;
            sof_frame  <= 11'd0;
            hs_pid     <= 4'd0;
            data_pid   <= 4'd0;
        end else begin
            state_q    <= state_d;
            xpacket_q  <= xpacket;
            pid_q      <= pid_d;
            cnt_q      <= cnt_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            crc5_q     <= crc5_d;
            crc16_q    <= crc16_d;
            tok_valid  <= tok_valid_d;
            sof_valid  <= sof_valid_d;
            hs_valid   <= hs_valid_d;
            data_start <= data_start_d;
            data_end   <= data_end_d;
            data_ok    <= data_ok_d;
            rx_error   <= rx_error_d;
            tok_pid    <= tok_pid_d;
            tok_addr   <= tok_addr_d;
            tok_endp   <= tok_endp_d;
            sof_frame  <= sof_frame_d;
            hs_pid     <= hs_pid_d;
            data_pid   <= data_pid_d;
        end
    end

    usb_rx_crc_strip u_crc_strip (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (line_push),
        .flush     (pkt_rise),
        .din       (xdata),
        .out_valid (data_strobe),
        .out_byte  (data_byte),
        .occupancy (line_occ)
    );

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Self-checking bench for usb_rx_decoder: expected events are queued as packets
// are driven and matched in order against the pulses the decoder produces.
module tb_usb_rx_decoder;
    import usb_rx_decoder_pkg::*;

    typedef enum logic [2:0] {EvStart, EvByte, EvTok, EvSof, EvHs, EvEnd, EvErr} ev_kind_e;
    typedef struct packed {
        ev_kind_e    kind;
        logic [31:0] val;
    } ev_t;

    logic        clk, rst_n, xpacket, xdatastrobe, xcrc5_ok, xcrc16_ok;
    logic [3:0]  xpid;
    logic [7:0]  xdata;
    logic        tok_valid, sof_valid, hs_valid, data_start, data_strobe;
    logic        data_end, data_ok, rx_error;
    logic [3:0]  tok_pid, tok_endp, hs_pid, data_pid;
    logic [6:0]  tok_addr;
    logic [10:0] sof_frame;
    logic [7:0]  data_byte;

    int          checks = 0;
    int          errors = 0;
    ev_t         sb[$];
    ev_t         obs[$];
    ev_t         exp_ev;
    logic [7:0]  tx_q[$];

    usb_rx_decoder #(.MAX_PAYLOAD(1023)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .xpacket     (xpacket),
        .xpid        (xpid),
        .xdata       (xdata),
        .xdatastrobe (xdatastrobe),
        .xcrc5_ok    (xcrc5_ok),
        .xcrc16_ok   (xcrc16_ok),
        .tok_valid   (tok_valid),
        .tok_pid     (tok_pid),
        .tok_addr    (tok_addr),
        .tok_endp    (tok_endp),
        .sof_valid   (sof_valid),
        .sof_frame   (sof_frame),
        .hs_valid    (hs_valid),
        .hs_pid      (hs_pid),
        .data_start  (data_start),
        .data_pid    (data_pid),
        .data_byte   (data_byte),
        .data_strobe (data_strobe),
        .data_end    (data_end),
        .data_ok     (data_ok),
        .rx_error    (rx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at 1 ms, required finish");
        $fatal(1);
    end

    // Scoreboard: every pulse seen on the falling clock edge pops one expectation
    always @(negedge clk) begin
        if (rst_n) begin
            obs = {};
            if (data_start)  obs.push_back('{EvStart, {28'd0, data_pid}});
            if (data_strobe) obs.push_back('{EvByte, {24'd0, data_byte}});
            if (tok_valid)   obs.push_back('{EvTok, {17'd0, tok_pid, tok_addr, tok_endp}});
            if (sof_valid)   obs.push_back('{EvSof, {21'd0, sof_frame}});
            if (hs_valid)    obs.push_back('{EvHs, {28'd0, hs_pid}});
            if (data_end)    obs.push_back('{EvEnd, {31'd0, data_ok}});
            if (rx_error)    obs.push_back('{EvErr, 32'd0});
            foreach (obs[i]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind=%0d val=%h, required none",
                             obs[i].kind, obs[i].val);
                end else begin
                    exp_ev = sb.pop_front();
                    if (obs[i] !== exp_ev) begin
                        errors++;
                        $display("FAIL event_order: got kind=%0d val=%h, required kind=%0d val=%h",
                                 obs[i].kind, obs[i].val, exp_ev.kind, exp_ev.val);
                    end
                end
            end
        end
    end

    // Drives tx_q as one packet; caller sits 1 time unit after a rising clock edge
    task automatic send_pkt(input logic [3:0] pid, input int crc5_at, input logic crc16_last,
                            input bit on_fall, input int gap);
        int n;
        int ends;
        n = tx_q.size();
        xpacket = 1'b1;
        xpid    = pid;
        @(posedge clk); #1;
        checks++;
        if (data_start !== (pid[1:0] == 2'b11)) begin
            errors++;
            $display("FAIL data_start_timing: got %b, required %b", data_start,
                     (pid[1:0] == 2'b11));
        end
        for (int i = 0; i < n; i++) begin
            xdatastrobe = 1'b1;
            xdata       = tx_q[i];
            xcrc5_ok    = (i == crc5_at);
            xcrc16_ok   = (i == n - 1) ? crc16_last : 1'b0;
            if (on_fall && i == n - 1) xpacket = 1'b0;
            @(posedge clk); #1;
            xdatastrobe = 1'b0;
            xcrc5_ok    = 1'b0;
            xcrc16_ok   = 1'b0;
        end
        if (!(on_fall && n > 0)) begin
            xpacket = 1'b0;
            @(posedge clk); #1;
        end
        ends = int'(tok_valid) + int'(sof_valid) + int'(hs_valid) + int'(data_end)
             + int'(rx_error);
        checks++;
        if (ends != 1) begin
            errors++;
            $display("FAIL end_pulse_timing pid=%b: got %0d end pulses, required 1", pid, ends);
        end
        tx_q = {};
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; xpacket = 1'b0; xpid = 4'd0; xdata = 8'd0;
        xdatastrobe = 1'b0; xcrc5_ok = 1'b0; xcrc16_ok = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tok_valid, sof_valid, hs_valid, data_start, data_strobe, data_end, data_ok,
             rx_error} !== 8'd0) begin
            errors++;
            $display("FAIL reset_pulses: got %b, required 0", {tok_valid, sof_valid, hs_valid,
                     data_start, data_strobe, data_end, data_ok, rx_error});
        end
        checks++;
        if ({tok_pid, tok_addr, tok_endp, sof_frame, hs_pid, data_pid, data_byte} !== 45'd0) begin
            errors++;
            $display("FAIL reset_fields: got %h, required 0",
                     {tok_pid, tok_addr, tok_endp, sof_frame, hs_pid, data_pid, data_byte});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_token();
        tx_q = '{8'h95, 8'h01};
        sb.push_back('{EvTok, {17'd0, PidIn, 7'h15, 4'd3}});
        send_pkt(PidIn, 1, 1'b0, 1'b0, 2);
        checks++;
        if (tok_addr !== 7'h15 || tok_endp !== 4'd3) begin
            errors++;
            $display("FAIL token_hold: got addr=%h endp=%h, required 15/3", tok_addr, tok_endp);
        end
        tx_q = '{8'hff, 8'h07};
        sb.push_back('{EvTok, {17'd0, PidSetup, 7'h7f, 4'hf}});
        send_pkt(PidSetup, 1, 1'b0, 1'b1, 2);
        tx_q = '{8'h01, 8'h00};
        sb.push_back('{EvTok, {17'd0, PidPing, 7'h01, 4'h0}});
        send_pkt(PidPing, 1, 1'b0, 1'b0, 2);
        tx_q = '{8'h95, 8'h01};
        sb.push_back('{EvErr, 32'd0});
        send_pkt(PidOut, -1, 1'b0, 1'b0, 2);
        tx_q = '{8'h95, 8'h01, 8'h00};
        sb.push_back('{EvErr, 32'd0});
        send_pkt(PidOut, 1, 1'b0, 1'b0, 2);
        tx_q = '{8'h95};
        sb.push_back('{EvErr, 32'd0});
        send_pkt(PidIn, 0, 1'b0, 1'b0, 2);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL token_drain: %0d events outstanding, required 0", sb.size());
            sb = {};
        end
    endtask

    task automatic test_sof();
        tx_q = '{8'h34, 8'h05};
        sb.push_back('{EvSof, 32'h534});
        send_pkt(PidSof, 1, 1'b0, 1'b0, 2);
        tx_q = '{8'h34, 8'h05};
        sb.push_back('{EvErr, 32'd0});
        send_pkt(PidSof, -1, 1'b0, 1'b0, 2);
        checks++;
        if (sof_frame !== 11'h534) begin
            errors++;
            $display("FAIL sof_hold: got %h, required 534", sof_frame);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sof_drain: %0d events outstanding, required 0", sb.size());
            sb = {};
        end
    endtask

    task automatic test_data();
        tx_q = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h5a, 8'hc3};
        sb.push_back('{EvStart, {28'd0, PidData1}});
        sb.push_back('{EvByte, 32'hde});
        sb.push_back('{EvByte, 32'had});
        sb.push_back('{EvByte, 32'hbe});
        sb.push_back('{EvByte, 32'hef});
        sb.push_back('{EvEnd, 32'd1});
        send_pkt(PidData1, -1, 1'b1, 1'b0, 2);
        checks++;
        if (data_pid !== PidData1) begin
            errors++;
            $display("FAIL data_pid_hold: got %b, required %b", data_pid, PidData1);
        end
        // Last CRC byte arrives together with the end of packet
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        sb.push_back('{EvStart, {28'd0, PidMdata}});
        sb.push_back('{EvByte, 32'h11});
        sb.push_back('{EvByte, 32'h22});
        sb.push_back('{EvByte, 32'h33});
        sb.push_back('{EvEnd, 32'd1});
        send_pkt(PidMdata, -1, 1'b1, 1'b1, 2);
        tx_q = '{8'h77, 8'h12, 8'h34};
        sb.push_back('{EvStart, {28'd0, PidData2}});
        sb.push_back('{EvByte, 32'h77});
        sb.push_back('{EvEnd, 32'd0});
        send_pkt(PidData2, -1, 1'b0, 1'b0, 2);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL data_drain: %0d events outstanding, required 0", sb.size());
            sb = {};
        end
    endtask

    task automatic test_zero_len();
        tx_q = '{8'h00, 8'h00};
        sb.push_back('{EvStart, {28'd0, PidData0}});
        sb.push_back('{EvEnd, 32'd1});
        send_pkt(PidData0, -1, 1'b1, 1'b0, 2);
        tx_q = '{8'h00};
        sb.push_back('{EvStart, {28'd0, PidData0}});
        sb.push_back('{EvEnd, 32'd0});
        send_pkt(PidData0, -1, 1'b1, 1'b0, 2);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL zero_len_drain: %0d events outstanding, required 0", sb.size());
            sb = {};
        end
    endtask

    task automatic test_handshake();
        sb.push_back('{EvHs, {28'd0, PidAck}});
        send_pkt(PidAck, -1, 1'b0, 1'b0, 2);
        checks++;
        if (hs_pid !== 4'b0010) begin
            errors++;
            $display("FAIL hs_pid_hold: got %b, required 0010", hs_pid);
        end
        tx_q = '{8'h42};
        sb.push_back('{EvErr, 32'd0});
        send_pkt(PidAck, -1, 1'b0, 1'b0, 2);
        sb.push_back('{EvHs, {28'd0, PidStall}});
        send_pkt(PidStall, -1, 1'b0, 1'b0, 2);
        sb.push_back('{EvErr, 32'd0});
        send_pkt(4'b1000, -1, 1'b0, 1'b0, 2);
        tx_q = '{8'h01, 8'h02, 8'h03};
        sb.push_back('{EvErr, 32'd0});
        send_pkt(4'b1100, -1, 1'b1, 1'b0, 2);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL handshake_drain: %0d events outstanding, required 0", sb.size());
            sb = {};
        end
    endtask

    task automatic test_max_payload();
        logic [7:0] b;
        for (int len = 1023; len <= 1024; len++) begin
            sb.push_back('{EvStart, {28'd0, PidData0}});
            for (int i = 0; i < len + 2; i++) begin
                b = 8'($urandom_range(0, 255));
                tx_q.push_back(b);
                if (i < len) sb.push_back('{EvByte, {24'd0, b}});
            end
            sb.push_back('{EvEnd, {31'd0, (len <= 1023)}});
            send_pkt(PidData0, -1, 1'b1, 1'b0, 2);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL max_payload_drain: %0d events outstanding, required 0", sb.size());
            sb = {};
        end
    endtask

    task automatic test_back_to_back();
        tx_q = '{8'h2a, 8'h03};
        sb.push_back('{EvTok, {17'd0, PidOut, 7'h2a, 4'h6}});
        send_pkt(PidOut, 1, 1'b0, 1'b0, 0);
        tx_q = '{8'h9c, 8'h01, 8'h02};
        sb.push_back('{EvStart, {28'd0, PidData1}});
        sb.push_back('{EvByte, 32'h9c});
        sb.push_back('{EvEnd, 32'd1});
        send_pkt(PidData1, -1, 1'b1, 1'b1, 0);
        sb.push_back('{EvHs, {28'd0, PidNyet}});
        send_pkt(PidNyet, -1, 1'b0, 1'b0, 0);
        sb.push_back('{EvHs, {28'd0, PidNak}});
        send_pkt(PidNak, -1, 1'b0, 1'b0, 2);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_drain: %0d events outstanding, required 0", sb.size());
            sb = {};
        end
    endtask

    task automatic test_reset_mid();
        sb.push_back('{EvStart, {28'd0, PidData0}});
        sb.push_back('{EvByte, 32'ha5});
        xpacket = 1'b1;
        xpid    = PidData0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            xdatastrobe = 1'b1;
            xdata       = (i == 0) ? 8'ha5 : 8'h3c;
            @(posedge clk); #1;
            xdatastrobe = 1'b0;
        end
        @(negedge clk); #1;
        rst_n   = 1'b0;
        xpacket = 1'b0;
        #1;
        checks++;
        if ({tok_valid, sof_valid, hs_valid, data_start, data_strobe, data_end, data_ok,
             rx_error} !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_pulses: got %b, required 0", {tok_valid, sof_valid,
                     hs_valid, data_start, data_strobe, data_end, data_ok, rx_error});
        end
        checks++;
        if ({tok_pid, tok_addr, tok_endp, sof_frame, hs_pid, data_pid, data_byte} !== 45'd0) begin
            errors++;
            $display("FAIL reset_mid_fields: got %h, required 0",
                     {tok_pid, tok_addr, tok_endp, sof_frame, hs_pid, data_pid, data_byte});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tx_q = '{8'haa, 8'h02};
        sb.push_back('{EvTok, {17'd0, PidOut, 7'h2a, 4'h5}});
        send_pkt(PidOut, 1, 1'b0, 1'b0, 2);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_drain: %0d events outstanding, required 0", sb.size());
            sb = {};
        end
    endtask

    initial begin
        test_reset();
        test_token();
        test_sof();
        test_data();
        test_zero_len();
        test_handshake();
        test_max_payload();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_rx_decoder.md
# usb_rx_decoder

Packet-level decoder directly downstream of `usb_recv`. It consumes the byte stream (`xpacket`, `xpid`, `xdata`, `xdatastrobe`, `xcrc5_ok`, `xcrc16_ok`) and classifies each packet as a token, SOF, handshake or data packet. It extracts token fields and streams data payload with the two CRC16 bytes stripped, and it reports per-packet success or error as single-cycle events for the device/endpoint logic.

## Interface
- `MAX_PAYLOAD`, default 1023: largest legal data payload in bytes. Longer packets end with `data_ok=0`.
- `clk` in 1: clock, the same 48 MHz domain as `usb_recv`.
- `rst_n` in 1: reset, asynchronous, active-low.
- `xpacket` in 1: high from the cycle after a valid PID until end of packet.
- `xpid` in 4: PID; stable while `xpacket` is high.
- `xdata` in 8: received byte; `xdata[0]` is the first bit on the wire.
- `xdatastrobe` in 1: one-cycle pulse, `xdata` valid.
- `xcrc5_ok`, `xcrc16_ok` in 1 each: CRC residue check including the byte just strobed.
- `tok_valid` out 1: pulse, IN/OUT/SETUP/PING token accepted.
- `tok_pid` out 4: PID of the accepted token.
- `tok_addr` out 7: address from the token.
- `tok_endp` out 4: endpoint from the token.
- `sof_valid` out 1: pulse, SOF accepted.
- `sof_frame` out 11: frame number from the SOF.
- `hs_valid` out 1: pulse, handshake (ACK/NAK/STALL/NYET) accepted.
- `hs_pid` out 4: PID of the handshake.
- `data_start` out 1: pulse at the start of a DATA0/1/2/MDATA packet.
- `data_pid` out 4: PID of the data packet, held for its duration.
- `data_byte` out 8, `data_strobe` out 1: payload byte and its valid pulse; CRC bytes are never emitted.
- `data_end` out 1, `data_ok` out 1: end of data packet; `data_ok` is qualified by `data_end`.
- `rx_error` out 1: pulse, malformed non-data packet.

## Operation
- End of packet is the falling edge of `xpacket`, detected with a registered copy `xpacket_q`. Start of packet is the rising edge.
- On the rising edge, the PID is classified by `xpid[1:0]`:
  - `01` is a token; `0100` (PING) is also treated as a token.
  - `11` is data.
  - `10` is a handshake.
  - Any other PID (PRE/ERR, SPLIT, reserved) enters DISCARD.
- States and transitions:
  - IDLE → TOKEN, DATA, HSHAKE or DISCARD on the rising edge. Every state returns to IDLE on the falling edge.
  - TOKEN: capture `b0` on the first strobe and `b1` on the second, along with `xcrc5_ok` sampled on the second. A third strobe sets an overlength flag.
    - At end: if exactly 2 bytes and CRC5 ok, pulse `tok_valid` (or `sof_valid` for PID `0101`); otherwise pulse `rx_error`.
    - `tok_addr = b0[6:0]`, `tok_endp = {b1[2:0], b0[7]}`, `sof_frame = {b1[2:0], b0}`.
  - HSHAKE: at end, 0 bytes received pulses `hs_valid`; any byte received pulses `rx_error`.
  - DATA: bytes pass through a 2-byte delay line (sub-module). A byte is emitted only once a newer byte pushes it out, so the final two bytes (the CRC16) remain in the line. `xcrc16_ok` is latched on every strobe.
    - At end, pulse `data_end` with `data_ok` = 1 only if all of these hold: byte count ≥ 2, latched CRC16 ok, payload ≤ `MAX_PAYLOAD`.
    - The 11-bit byte counter saturates at 2047.
  - DISCARD: bytes are ignored; at end, pulse `rx_error`.
- Reset: all pulse outputs are 0, the state is IDLE, and the counters and delay line are cleared. Field outputs (`tok_*`, `sof_frame`, `hs_pid`, `data_pid`, `data_byte`) reset to 0. A reset mid-packet drops the packet with no end event.

## Timing
- Rising edge of `xpacket` at cycle n → `data_start` at n+1.
- `xdatastrobe` at cycle n pushing out byte k → `data_strobe`/`data_byte` for byte k at n+1.
- Falling edge of `xpacket` at cycle n → `tok_valid`/`sof_valid`/`hs_valid`/`data_end`/`rx_error` at n+1.
  - Field outputs are valid in that same cycle and held until the next event of the same kind.
- `xdatastrobe` coinciding with the falling edge: the byte is counted first, then the end is evaluated.
- A rising edge in the same cycle as an end pulse is legal. The end is reported for the old packet; the new packet starts from IDLE.
- Every output pulse is exactly 1 cycle wide. At most one of `tok_valid`/`sof_valid`/`hs_valid`/`data_end`/`rx_error` fires per packet.

## Structure
- Shared package holds the PID constants (OUT, IN, SOF, SETUP, PING, DATA0/1/2, MDATA, ACK, NAK, STALL, NYET) and the PID-class constants, for reuse by transmit and endpoint logic.
- Sub-module `usb_rx_crc_strip`: the 2-byte delay line with push/flush/occupancy, emitting bytes only after a newer byte arrives.

## Test plan
- IN token, addr 0x15, endp 3, correct CRC5 (`b0=0x95`, `b1=0x01`, `crc5_ok=1` on the 2nd byte) → one `tok_valid`, `tok_pid=1001`, `tok_addr=0x15`, `tok_endp=3`.
- SOF with bytes `0x34`, `0x05` and CRC5 ok → `sof_valid`, `sof_frame=0x534`. The same packet with `crc5_ok=0` → `rx_error` only.
- DATA1 with 4 payload bytes `0xDE`, `0xAD`, `0xBE`, `0xEF` plus 2 CRC bytes, CRC16 ok → `data_start`, then 4 `data_strobe` with exactly those bytes, then `data_end` with `data_ok=1`.
- Zero-length DATA0 (CRC bytes only) → `data_start`, no `data_strobe`, `data_ok=1`. DATA0 with 1 byte → `data_ok=0`.
- ACK with no bytes → `hs_valid`, `hs_pid=0010`. ACK followed by 1 byte → `rx_error`. SPLIT PID → `rx_error`.
- Assert `rst_n` low mid-data packet → all outputs 0 immediately, no `data_end`. The next token after reset decodes correctly.
